// File: rtl/prog_counter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// prog_counter : programmable up-counter (one-shot / auto-reload) with
//                pause/hold, terminal flags and a saturating period count.
// Revision     : 1.0
// -----------------------------------------------------------------------------
module prog_counter #(
  parameter int CNT_WIDTH = 4,
  parameter int PER_WIDTH = 8,
  parameter int DEF_MAX   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 pause,
  input  logic                 mode,
  input  logic [CNT_WIDTH-1:0] cnt_max,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 busy,
  output logic                 done_comb,
  output logic                 done_seq,
  output logic [PER_WIDTH-1:0] periods,
  output logic                 cfg_err
);

  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] C_DEF_MAX = CNT_WIDTH'(DEF_MAX);
  localparam logic [PER_WIDTH-1:0] C_PER_ONE = PER_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] max_q, max_d;
  logic                 mode_q, mode_d;
  logic [PER_WIDTH-1:0] periods_q, periods_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 done_seq_q;
  logic                 done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      max_q      <= C_DEF_MAX;
      mode_q     <= 1'b0;
      periods_q  <= '0;
      cfg_err_q  <= 1'b0;
      done_seq_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      max_q      <= max_d;
      mode_q     <= mode_d;
      periods_q  <= periods_d;
      cfg_err_q  <= cfg_err_d;
      done_seq_q <= done_d;
    end
  end

  // Priority: stop > start > pause > normal counting.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    max_d     = max_q;
    mode_d    = mode_q;
    periods_d = periods_q;
    cfg_err_d = 1'b0;
    if (stop) begin
      state_d = IDLE;
      count_d = '0;
    end else if (start) begin
      if (cnt_max != '0) begin
        max_d     = cnt_max;
        mode_d    = mode;
        count_d   = C_CNT_ONE;
        periods_d = '0;
        state_d   = RUN;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (pause) begin
            state_d = HOLD;
          end else if (count_q >= max_q) begin
            if (periods_q != '1) begin
              periods_d = periods_q + C_PER_ONE;
            end
            if (mode_q) begin
              count_d = C_CNT_ONE;
            end else begin
              count_d = '0;
              state_d = IDLE;
            end
          end else begin
            count_d = count_q + C_CNT_ONE;
          end
        end
        HOLD: begin
          if (!pause) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign done_d    = (state_q == RUN) && (count_q == max_q);
  assign done_comb = done_d;
  assign done_seq  = done_seq_q;
  assign count     = count_q;
  assign busy      = (state_q != IDLE);
  assign periods   = periods_q;
  assign cfg_err   = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_counter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_prog_counter : directed self-checking bench for prog_counter.
// Revision        : 1.0
// -----------------------------------------------------------------------------
module tb_prog_counter;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       pause;
  logic       mode;
  logic [3:0] cnt_max;

  logic [3:0] count;
  logic       busy;
  logic       done_comb;
  logic       done_seq;
  logic [7:0] periods;
  logic       cfg_err;

  logic [3:0] count2;
  logic       busy2;
  logic       done_comb2;
  logic       done_seq2;
  logic [1:0] periods2;
  logic       cfg_err2;

  int n_vec;
  int n_err;

  prog_counter u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .mode      (mode),
    .cnt_max   (cnt_max),
    .count     (count),
    .busy      (busy),
    .done_comb (done_comb),
    .done_seq  (done_seq),
    .periods   (periods),
    .cfg_err   (cfg_err)
  );

  prog_counter #(.PER_WIDTH(2)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .mode      (mode),
    .cnt_max   (cnt_max),
    .count     (count2),
    .busy      (busy2),
    .done_comb (done_comb2),
    .done_seq  (done_seq2),
    .periods   (periods2),
    .cfg_err   (cfg_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    pause   = 1'b0;
    mode    = 1'b0;
    cnt_max = 4'd0;

    // Reset state
    #2;
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_comb", done_comb, 0);
    chk("rst_done_seq", done_seq, 0);
    chk("rst_periods", periods, 0);
    chk("rst_cfg_err", cfg_err, 0);
    #20;
    rst = 1'b1;

    // One-shot, cnt_max = 3
    tick();
    start = 1'b1; cnt_max = 4'd3; mode = 1'b0;
    tick();
    start = 1'b0;
    chk("os_count1", count, 1);
    chk("os_busy1", busy, 1);
    chk("os_done1", done_comb, 0);
    tick();
    chk("os_count2", count, 2);
    tick();
    chk("os_count3", count, 3);
    chk("os_done3", done_comb, 1);
    chk("os_dseq3", done_seq, 0);
    tick();
    chk("os_count_wrap", count, 0);
    chk("os_busy_wrap", busy, 0);
    chk("os_periods", periods, 1);
    chk("os_done_wrap", done_comb, 0);
    chk("os_dseq_wrap", done_seq, 1);
    tick();
    chk("os_dseq_low", done_seq, 0);

    // Auto-reload, cnt_max = 4; cnt_max/mode changes while busy are ignored
    start = 1'b1; cnt_max = 4'd4; mode = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) begin
        start = 1'b0; cnt_max = 4'd2; mode = 1'b0;
      end
      chk("ar_count", count, ((k - 1) % 4) + 1);
      chk("ar_done", done_comb, (k % 4 == 0) ? 1 : 0);
      chk("ar_periods", periods, (k - 1) / 4);
    end
    tick();
    chk("ar_count_reload", count, 1);
    chk("ar_periods3", periods, 3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_count", count, 0);
    chk("stop_busy", busy, 0);
    chk("stop_periods_kept", periods, 3);

    // Pause for 3 cycles at count = 2, cnt_max = 5
    start = 1'b1; cnt_max = 4'd5; mode = 1'b0;
    tick();
    start = 1'b0;
    chk("ps_count1", count, 1);
    tick();
    chk("ps_count2", count, 2);
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ps_hold_count", count, 2);
      chk("ps_hold_busy", busy, 1);
      chk("ps_hold_done", done_comb, 0);
    end
    pause = 1'b0;
    tick();
    chk("ps_resume_count", count, 2);
    tick();
    chk("ps_count3", count, 3);
    tick();
    chk("ps_count4", count, 4);
    tick();
    chk("ps_count5", count, 5);
    chk("ps_done5", done_comb, 1);
    tick();
    chk("ps_end_count", count, 0);
    chk("ps_end_busy", busy, 0);
    chk("ps_end_periods", periods, 1);

    // Illegal start (cnt_max = 0)
    start = 1'b1; cnt_max = 4'd0; mode = 1'b1;
    tick();
    start = 1'b0;
    chk("ce_pulse", cfg_err, 1);
    chk("ce_busy", busy, 0);
    chk("ce_count", count, 0);
    chk("ce_periods", periods, 1);
    tick();
    chk("ce_pulse_end", cfg_err, 0);
    chk("ce_busy2", busy, 0);

    // start + stop on the same edge during RUN
    start = 1'b1; cnt_max = 4'd3; mode = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("ss_count2", count, 2);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_count", count, 0);
    chk("ss_busy", busy, 0);
    chk("ss_cfg_err", cfg_err, 0);

    // Asynchronous reset at count = 2
    start = 1'b1; cnt_max = 4'd3; mode = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("ar_rst_pre_count", count, 2);
    rst = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done_comb", done_comb, 0);
    chk("arst_done_seq", done_seq, 0);
    chk("arst_periods", periods, 0);
    chk("arst_cfg_err", cfg_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("arst_idle_count", count, 0);
    chk("arst_idle_busy", busy, 0);

    // max = 1 auto-reload: done every RUN cycle, period counters saturate
    start = 1'b1; cnt_max = 4'd1; mode = 1'b1;
    tick();
    start = 1'b0;
    chk("m1_count", count, 1);
    chk("m1_done", done_comb, 1);
    chk("m1_periods0", periods, 0);
    chk("m1_periods2_0", periods2, 0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("m1_done_run", done_comb, 1);
      chk("m1_count_run", count, 1);
      chk("m1_periods", periods, k);
      chk("m1_periods_sat", periods2, (k > 3) ? 3 : k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 Parameter CNT_WIDTH, default 4: width of count and terminal-value paths; legal range 2..16.
REQ-002 Parameter PER_WIDTH, default 8: width of the completed-period counter.
REQ-003 Parameter DEF_MAX, default 3: terminal value loaded into max_reg at reset.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  pulse; samples cnt_max and mode, then (re)starts counting.
REQ-007 stop  input  1  pulse; aborts the run and returns to IDLE.
REQ-008 pause  input  1  level; freezes count while RUN.
REQ-009 mode  input  1  0 = one-shot, 1 = auto-reload; sampled on start.
REQ-010 cnt_max  input  CNT_WIDTH  terminal value; sampled on start.
REQ-011 count  output  CNT_WIDTH  current count, registered.
REQ-012 busy  output  1  high in RUN or HOLD.
REQ-013 done_comb  output  1  combinational terminal flag.
REQ-014 done_seq  output  1  done_comb delayed one clk.
REQ-015 periods  output  PER_WIDTH  completed-period count, saturating.
REQ-016 cfg_err  output  1  one-cycle pulse on an illegal start.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and HOLD; busy = (state != IDLE).
REQ-018 A start in any state with cnt_max != 0 SHALL:
- latch cnt_max into max_reg and mode into mode_reg;
- set count to 1 and periods to 0;
- enter RUN on the same edge.
REQ-019 A start with cnt_max == 0 SHALL pulse cfg_err for one cycle and leave state, count, max_reg and periods unchanged.
REQ-020 In RUN with count < max_reg and pause low, count SHALL increment by 1 per cycle.
REQ-021 In RUN with count == max_reg, the next edge SHALL:
- increment periods, saturating at all-ones;
- if mode_reg = 0, set count to 0 and go to IDLE;
- if mode_reg = 1, set count to 1 and stay in RUN.
REQ-022 done_comb SHALL equal (state == RUN) && (count == max_reg); it SHALL be low in IDLE and HOLD.
REQ-023 done_seq SHALL be a register of done_comb, giving one clk of latency.
REQ-024 In RUN, pause high SHALL move the FSM to HOLD on the next edge with count frozen.
REQ-025 In HOLD, pause low SHALL return the FSM to RUN with count unchanged; counting resumes on the following edge.
REQ-026 stop SHALL take the FSM to IDLE and set count to 0 in any state; periods SHALL be retained.
REQ-027 Priority on the same edge SHALL be stop > start > pause > normal counting.
REQ-028 With max_reg = 1 in auto-reload, done_comb SHALL stay high in every RUN cycle and periods SHALL increment every cycle.
REQ-029 Changes to cnt_max or mode while busy SHALL have no effect until the next start.
REQ-030 count SHALL never exceed max_reg, and count SHALL be 0 whenever the FSM is in IDLE.

Reset
REQ-031 While rst = 0, the block SHALL asynchronously force:
- state to IDLE and max_reg to DEF_MAX;
- mode_reg, count, periods, done_seq and cfg_err to 0.
REQ-032 Reset asserted during RUN or HOLD SHALL abort the run immediately; after release, the FSM SHALL remain in IDLE until a start.

Verification
REQ-033 start with cnt_max = 3, mode = 0 -> count 1,2,3,0; done_comb high only in the count = 3 cycle, done_seq one cycle later; periods = 1; busy low after the wrap.
REQ-034 start with cnt_max = 4, mode = 1, run 12 cycles -> count repeats 1,2,3,4; done_comb pulses every 4th cycle; periods = 3.
REQ-035 cnt_max = 5; pause for 3 cycles at count = 2 -> count holds at 2 with busy high and done_comb low; completion is delayed by 3 cycles plus 1 resume cycle.
REQ-036 start with cnt_max = 0 -> cfg_err one-cycle pulse; state stays IDLE; count stays 0.
REQ-037 start and stop asserted on the same edge during RUN -> IDLE with count = 0; reset asserted at count = 2 -> all outputs 0 immediately.
REQ-038 PER_WIDTH = 2, cnt_max = 1, mode = 1, run 6 cycles -> periods saturates at 3.
